// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: word size, NOP encoding,
// default reset PC and the {inst, pc} entry crossing IF/ID.
package fetch_stage_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [WORD_SIZE-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [WORD_SIZE-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic [WORD_SIZE-1:0] inst;
    logic [WORD_SIZE-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD_SIZE-1:0] align_pc(
    input logic [WORD_SIZE-1:0] pc
  );
    return {pc[WORD_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: imem request/response, redirect and the
// valid/ready instruction handoff toward decode.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [WORD_SIZE-1:0] imem_req_addr;
  logic                 imem_rsp_valid;
  logic [WORD_SIZE-1:0] imem_rsp_data;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [WORD_SIZE-1:0] inst;
  logic [WORD_SIZE-1:0] inst_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Circular buffer with push/pop/clear and occupancy count;
// holds fetch entries or, as the tag queue, bare PCs.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests, buffer to decode.
// Define FETCH_PERF_CNT_EN to add perf_fetched/perf_stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          rst,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] tag_head;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        buf_cnt;
  logic [CW:0]          in_use;
  logic                 req_fire;
  logic                 rsp;
  logic                 drop;
  logic                 keep;
  logic                 pop;
  logic                 buf_valid;
  fetch_entry_t         rsp_entry;
  fetch_entry_t         buf_head;

  // Tag queue occupancy is exactly the number of outstanding requests.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [WORD_SIZE-1:0])
  ) u_tags (
    .clk   (CLK),
    .rst   (rst),
    .clear (1'b0),
    .push  (req_fire),
    .pop   (rsp),
    .din   (pc),
    .head  (tag_head),
    .count (outstanding)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_buf (
    .clk   (CLK),
    .rst   (rst),
    .clear (bus.redirect_valid),
    .push  (keep),
    .pop   (pop),
    .din   (rsp_entry),
    .head  (buf_head),
    .count (buf_cnt)
  );

  assign in_use = {1'b0, outstanding} + {1'b0, buf_cnt};

  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (in_use < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp      = bus.imem_rsp_valid;
  assign drop     = rsp && (drop_cnt != '0);
  assign keep     = rsp && !drop && !bus.redirect_valid;

  assign rsp_entry.inst = bus.imem_rsp_data;
  assign rsp_entry.pc   = tag_head;

  assign buf_valid      = buf_cnt != '0;
  assign pop            = buf_valid && bus.inst_ready &&
                          !bus.redirect_valid;
  assign bus.inst_valid = buf_valid;
  assign bus.inst       = buf_valid ? buf_head.inst : NOP_INST;
  assign bus.inst_pc    = buf_valid ? buf_head.pc : '0;

  always_ff @(posedge CLK) begin
    if (rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= align_pc(bus.redirect_pc);
      drop_cnt <= outstanding - CW'(rsp);
    end else begin
      if (req_fire) pc <= pc + WORD_SIZE'(4);
      if (drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  rsp_needs_credit: assert property (
    @(posedge CLK) disable iff (rst)
    bus.imem_rsp_valid |-> (outstanding != '0)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (buf_valid && !bus.inst_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model, directed
// scenarios and randomized traffic with redirects and resets.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    bit          doomed;
  } oreq_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mrsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_stage_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_stage #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // stimulus controls, applied at the next negedge
  bit          rst_c, req_rdy, irdy, redir;
  logic [31:0] redir_pc;
  int          lat_lo, lat_hi;

  // reference model
  fetch_entry_t iq[$];
  oreq_t        oq[$];
  mrsp_t        mq[$];
  logic [31:0]  mpc;
  logic [31:0]  m_pf, m_ps;
  int           cyc_n, last_due;

  // observations
  logic [31:0] acc_q[$];
  logic [31:0] pop_pcs[$];
  int          n_acc, n_pop, n_stl;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_inst, s_ipc, s_pf, s_ps;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a << 7) ^ (a >> 3) ^ 32'h1357_0013;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$],
                                       input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic cyc();
    oreq_t       o;
    logic [31:0] d;
    logic        rsp_v, e_rv, e_iv;
    int          due;
    @(negedge clk);
    rst = rst_c;
    rsp_v = !rst && mq.size() > 0 && mq[0].due <= cyc_n;
    bus.imem_req_ready = req_rdy;
    bus.inst_ready     = irdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir_pc;
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_v ? mq[0].data : $urandom();
    #1;
    e_rv = !rst && !redir && (oq.size() + iq.size() < DEPTH);
    e_iv = iq.size() > 0;
    chk("req_valid", bus.imem_req_valid, e_rv);
    if (e_rv) chk("req_addr", bus.imem_req_addr, mpc);
    chk("inst_valid", bus.inst_valid, e_iv);
    if (e_iv) begin
      chk("inst", bus.inst, iq[0].inst);
      chk("inst_pc", bus.inst_pc, iq[0].pc);
    end
    s_pf = 0;
    s_ps = 0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_pf);
    chk("perf_stall", perf_stall, m_ps);
    s_pf = perf_fetched;
    s_ps = perf_stall;
`endif
    s_rv   = bus.imem_req_valid;
    s_iv   = bus.inst_valid;
    s_addr = bus.imem_req_addr;
    s_inst = bus.inst;
    s_ipc  = bus.inst_pc;
    if (!rst && bus.imem_req_valid && req_rdy) begin
      acc_q.push_back(bus.imem_req_addr);
      n_acc++;
    end
    if (!rst && bus.inst_valid && irdy && !redir) begin
      pop_pcs.push_back(bus.inst_pc);
      n_pop++;
    end
    if (!rst && bus.inst_valid && !irdy) n_stl++;
    if (rst) begin
      iq.delete();
      oq.delete();
      mq.delete();
      mpc  = 32'h0;
      m_pf = 0;
      m_ps = 0;
    end else begin
      if (e_iv && irdy && !redir) begin
        void'(iq.pop_front());
        m_pf++;
      end
      if (e_iv && !irdy) m_ps++;
      if (rsp_v) begin
        o = oq.pop_front();
        d = mq[0].data;
        void'(mq.pop_front());
        if (!o.doomed && !redir) iq.push_back('{inst: d, pc: o.addr});
      end
      if (redir) begin
        iq.delete();
        foreach (oq[i]) oq[i].doomed = 1'b1;
        mpc = {redir_pc[31:2], 2'b00};
      end else if (e_rv && req_rdy) begin
        oq.push_back('{addr: mpc, doomed: 1'b0});
        due = cyc_n + int'($urandom_range(lat_hi, lat_lo));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{data: mdata(mpc), due: due});
        mpc = mpc + 32'd4;
      end
    end
    cyc_n++;
  endtask

  task automatic clear_obs();
    acc_q.delete();
    pop_pcs.delete();
    n_acc = 0;
    n_pop = 0;
    n_stl = 0;
  endtask

  initial begin
    int first_iv;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    rst_c = 1; req_rdy = 1; irdy = 1; redir = 0; redir_pc = 0;
    lat_lo = 1; lat_hi = 1;
    mpc = 0; m_pf = 0; m_ps = 0; cyc_n = 0; last_due = 0;

    // reset, then in-order fetch from 0
    cyc();
    chk("rst_req_valid", s_rv, 0);
    chk("rst_inst_valid", s_iv, 0);
    chk("rst_inst", s_inst, 32'h0000_0013);
    chk("rst_inst_pc", s_ipc, 0);
    cyc();
    rst_c = 0;
    clear_obs();
    first_iv = -1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (s_iv && first_iv < 0) first_iv = i;
    end
    chk("first_inst_valid_cycle", first_iv, 2);
    chk("req_addr_0", qget(acc_q, 0), 32'h0);
    chk("req_addr_1", qget(acc_q, 1), 32'h4);
    chk("req_addr_2", qget(acc_q, 2), 32'h8);
    chk("inst_pc_0", qget(pop_pcs, 0), 32'h0);
    chk("inst_pc_1", qget(pop_pcs, 1), 32'h4);
    chk("inst_pc_2", qget(pop_pcs, 2), 32'h8);

    // decode stall fills the credits
    irdy = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("stall_in_flight", n_acc - n_pop, DEPTH);
    chk("stall_req_valid", s_rv, 0);
    irdy = 1;
    cyc();
    cyc();
    chk("resume_req_valid", s_rv, 1);
    for (int i = 0; i < 3; i++) cyc();

    // redirect with two requests outstanding
    rst_c = 1; cyc(); rst_c = 0;
    lat_lo = 3; lat_hi = 3;
    cyc();
    cyc();
    redir = 1; redir_pc = 32'h100;
    cyc();
    chk("redir_cycle_req_valid", s_rv, 0);
    redir = 0; lat_lo = 1; lat_hi = 1;
    clear_obs();
    for (int i = 0; i < 12; i++) cyc();
    chk("redir2_first_req", qget(acc_q, 0), 32'h100);
    chk("redir2_first_inst_pc", qget(pop_pcs, 0), 32'h100);

    // redirect coincident with a response and a pop, misaligned target
    rst_c = 1; cyc(); rst_c = 0;
    cyc();
    cyc();
    redir = 1; redir_pc = 32'h103;
    cyc();
    chk("coinc_inst_valid_before", s_iv, 1);
    redir = 0;
    clear_obs();
    cyc();
    chk("coinc_inst_valid_after", s_iv, 0);
    chk("coinc_req_valid_after", s_rv, 1);
    chk("misaligned_req_addr", s_addr, 32'h100);
    for (int i = 0; i < 10; i++) cyc();
    chk("coinc_first_inst_pc", qget(pop_pcs, 0), 32'h100);

    // pc wrap at the top of the address space
    rst_c = 1; cyc(); rst_c = 0;
    redir = 1; redir_pc = 32'hFFFF_FFFC;
    cyc();
    redir = 0;
    cyc();
    chk("wrap_req_valid_a", s_rv, 1);
    chk("wrap_req_addr_a", s_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_req_valid_b", s_rv, 1);
    chk("wrap_req_addr_b", s_addr, 32'h0);

    // randomized traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      rst_c    = ($urandom_range(0, 199) == 0);
      req_rdy  = ($urandom_range(0, 3) != 0);
      irdy     = ($urandom_range(0, 9) < 7);
      redir    = ($urandom_range(0, 24) == 0);
      redir_pc = $urandom();
      cyc();
    end

`ifdef FETCH_PERF_CNT_EN
    // 10 pops with 3 stall cycles, then reset clears both
    rst_c = 1; redir = 0; req_rdy = 1; irdy = 1;
    lat_lo = 1; lat_hi = 1;
    cyc();
    rst_c = 0;
    clear_obs();
    for (int i = 0; i < 200 && n_pop < 10; i++) begin
      irdy = !(n_stl < 3 && n_pop >= 3 && iq.size() > 0);
      cyc();
    end
    chk("perf_setup_pops", n_pop, 10);
    chk("perf_setup_stalls", n_stl, 3);
    irdy = 1;
    rst_c = 1;
    cyc();
    chk("perf_fetched_10", s_pf, 10);
    chk("perf_stall_3", s_ps, 3);
    rst_c = 0;
    cyc();
    chk("perf_fetched_rst", s_pf, 0);
    chk("perf_stall_rst", s_ps, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
